// File: rtl/dmem_pkg.sv
// Shared constants and state encoding for the data-memory responder.
package dmem_pkg;

  localparam int AW    = 7;
  localparam int DW    = 32;
  localparam int DEPTH = 128;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/dmem_array.sv
// DEPTH x DW storage with one synchronous write port and one asynchronous read port.
module dmem_array #(
  parameter int AW    = 7,
  parameter int DW    = 32,
  parameter int DEPTH = 128
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];

  // Storage is deliberately not reset; the responder's init pass clears it.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the MIPS data-memory interface: init-clear FSM,
// one-entry posted-write staging with read forwarding, and a held read register.
module dmem_responder #(
  parameter int AW         = 7,
  parameter int DW         = 32,
  parameter int DEPTH      = 128,
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          CEN,
  input  logic          WEN,
  input  logic [AW-1:0] A,
  input  logic [DW-1:0] D,
  input  logic          OEN,
  output logic [DW-1:0] Q,
  output logic          busy,
  output logic          drop_err
);

  import dmem_pkg::*;

  state_e        state_q;
  logic [AW-1:0] cnt_q;
  logic          busy_q;
  logic          drop_q;
  logic [DW-1:0] q_q;
  logic          pend_v_q;
  logic [AW-1:0] pend_addr_q;
  logic [DW-1:0] pend_data_q;

  logic          wr_s;
  logic          rd_s;
  logic          mem_we_s;
  logic [AW-1:0] mem_waddr_s;
  logic [DW-1:0] mem_wdata_s;
  logic [DW-1:0] mem_rdata_s;
  logic [DW-1:0] rd_data_s;

  assign wr_s = ~CEN & ~WEN;
  assign rd_s = ~CEN &  WEN;

  // The single array write port is shared by the clear pass and the staged commit.
  always_comb begin
    mem_we_s    = 1'b0;
    mem_waddr_s = pend_addr_q;
    mem_wdata_s = pend_data_q;
    if (state_q == INIT) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = cnt_q;
      mem_wdata_s = {DW{1'b0}};
    end else begin
      mem_we_s    = pend_v_q;
    end
  end

  // Forward from the entry staged before this edge so a read-after-write is coherent.
  assign rd_data_s = (pend_v_q && (pend_addr_q == A)) ? pend_data_q : mem_rdata_s;

  dmem_array #(
    .AW    (AW),
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_array (
    .clk     (clk),
    .we_i    (mem_we_s),
    .waddr_i (mem_waddr_s),
    .wdata_i (mem_wdata_s),
    .raddr_i (A),
    .rdata_o (mem_rdata_s)
  );

  // Init-clear / run FSM with the staging register and held read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= INIT_CLEAR ? INIT : RUN;
      cnt_q       <= {AW{1'b0}};
      busy_q      <= INIT_CLEAR;
      drop_q      <= 1'b0;
      q_q         <= {DW{1'b0}};
      pend_v_q    <= 1'b0;
      pend_addr_q <= {AW{1'b0}};
      pend_data_q <= {DW{1'b0}};
    end else begin
      case (state_q)
        INIT: begin
          cnt_q    <= cnt_q + AW'(1);
          pend_v_q <= 1'b0;
          if (!CEN) begin
            drop_q <= 1'b1;
          end
          if (cnt_q == AW'(DEPTH - 1)) begin
            state_q <= RUN;
            busy_q  <= 1'b0;
          end
        end
        RUN: begin
          if (wr_s) begin
            pend_v_q    <= 1'b1;
            pend_addr_q <= A;
            pend_data_q <= D;
          end else begin
            pend_v_q <= 1'b0;
            if (rd_s) begin
              q_q <= rd_data_s;
            end
          end
        end
        default: begin
          state_q  <= RUN;
          busy_q   <= 1'b0;
          pend_v_q <= 1'b0;
        end
      endcase
    end
  end

  assign Q        = OEN ? {DW{1'b0}} : q_q;
  assign busy     = busy_q;
  assign drop_err = drop_q;

endmodule
